// File: rtl/sat_pkg.sv
// Shared types and helpers for the saturating accumulator: FSM state encoding,
// default widths and a fixed-width saturating add for reference use.
package sat_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int IN_W_DEF  = 4;
    localparam int ACC_W_DEF = 8;
    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {ACC_W_DEF{1'b1}};

    typedef struct packed {
        logic [ACC_W_DEF-1:0] sum;
        logic                 ovf;
    } sat_res_t;

    function automatic sat_res_t sat_add(input logic [ACC_W_DEF-1:0] a,
                                         input logic [ACC_W_DEF-1:0] b);
        logic [ACC_W_DEF:0] full;
        sat_res_t           res;
        full    = {1'b0, a} + {1'b0, b};
        res.ovf = full[ACC_W_DEF];
        res.sum = res.ovf ? ACC_MAX : full[ACC_W_DEF-1:0];
        return res;
    endfunction

endpackage

// File: rtl/sat_add_u.sv
// Combinational unsigned saturating adder: sum clamps to all-ones on carry-out,
// ovf flags that the true sum did not fit in W bits.
module sat_add_u #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o = full[W];
    assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/sat_accum.sv
// Frame accumulator: sums narrow unsigned samples into a clamped ACC_W total, one result
// per in_last frame over valid/ready. SAT_ACCUM_COUNT_EN adds a saturating beat count.
module sat_accum
    import sat_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
`ifdef SAT_ACCUM_COUNT_EN
    output logic [CNT_W-1:0] out_count,
`endif
    output logic             out_sat
);

    if (ACC_W <= IN_W || CNT_W < 1) begin : g_bad_cfg
        $error("sat_accum: ACC_W must exceed IN_W and CNT_W must be positive");
    end

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic             out_vld_q, out_vld_d;
    logic [ACC_W-1:0] out_dat_q, out_dat_d;
    logic             out_sat_q, out_sat_d;

    logic [ACC_W-1:0] acc_sum;
    logic             acc_ovf;
    logic             beat_ovf;
    logic             accept;

    // in_ready depends on state only, so out_ready never reaches it combinationally.
    assign in_ready = (state_q == ACCUM);
    assign accept   = in_valid && in_ready;

    sat_add_u #(.W(ACC_W)) u_acc_add (
        .a_i   (acc_q),
        .b_i   ({{(ACC_W-IN_W){1'b0}}, in_data}),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

`ifdef SAT_ACCUM_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] cnt_sum;

    sat_add_u #(.W(CNT_W)) u_cnt_add (
        .a_i   (cnt_q),
        .b_i   ({{(CNT_W-1){1'b0}}, 1'b1}),
        .sum_o (cnt_sum),
        .ovf_o (beat_ovf)
    );

    always_comb begin
        cnt_d     = cnt_q;
        out_cnt_d = out_cnt_q;
        if (state_q == ACCUM && accept) begin
            cnt_d = cnt_sum;
            if (in_last) begin
                out_cnt_d = cnt_sum;
            end
        end else if (state_q == HOLD && out_ready) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign out_count = out_cnt_q;
`else
    assign beat_ovf = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_sat_d = out_sat_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_sum;
                    sat_d = sat_q | acc_ovf | beat_ovf;
                    if (in_last) begin
                        out_dat_d = acc_sum;
                        out_sat_d = sat_q | acc_ovf | beat_ovf;
                        out_vld_d = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                // out_vld_q is always set in HOLD, so out_ready alone completes the handshake.
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    acc_d     = '0;
                    sat_d     = 1'b0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sat_accum.sv
// Directed bench for sat_accum: hand-computed frame totals, clamping, hold/backpressure,
// reset mid-frame and idle gaps; out_count is checked when SAT_ACCUM_COUNT_EN is defined.
module tb_sat_accum;

    localparam int IN_W  = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;

    int n_assert;
    int n_fail;

    sat_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SAT_ACCUM_COUNT_EN
        .out_count (out_count),
`endif
        .out_sat   (out_sat)
    );

`ifndef SAT_ACCUM_COUNT_EN
    assign out_count = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef SAT_ACCUM_COUNT_EN
        chk(tag, 32'(out_count), 32'(exp));
`else
        if (exp < 0) $display("unreachable %s", tag);
`endif
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk_cnt("rst_out_count", 0);

        // Frame 1, 2, 15 -> 18
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        chk("f1_no_early_valid", 32'(out_valid), 0);
        send(4'd15, 1'b1);
        chk("f1_valid", 32'(out_valid), 1);
        chk("f1_data", 32'(out_data), 18);
        chk("f1_sat", 32'(out_sat), 0);
        chk("f1_in_ready_hold", 32'(in_ready), 0);
        chk_cnt("f1_count", 3);
        tick();
        chk("f1_handshake_valid", 32'(out_valid), 0);
        chk("f1_handshake_ready", 32'(in_ready), 1);

        // 20 beats of 15 -> clamps at 255
        for (int i = 0; i < 20; i++) send(4'd15, (i == 19));
        chk("f2_valid", 32'(out_valid), 1);
        chk("f2_data", 32'(out_data), 255);
        chk("f2_sat", 32'(out_sat), 1);
        chk_cnt("f2_count", (20 > CNT_MAX) ? CNT_MAX : 20);
        tick();

        // Backpressure: 4, 4 held for 5 cycles with ignored in_valid pulses
        out_ready = 1'b0;
        send(4'd4, 1'b0);
        send(4'd4, 1'b1);
        chk("f3_valid", 32'(out_valid), 1);
        chk("f3_data", 32'(out_data), 8);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 4'd9;
            in_last  = 1'b1;
            tick();
            chk("f3_hold_valid", 32'(out_valid), 1);
            chk("f3_hold_data", 32'(out_data), 8);
            chk("f3_hold_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        chk("f3_release_valid", 32'(out_valid), 0);
        chk("f3_release_ready", 32'(in_ready), 1);
        send(4'd7, 1'b1);
        chk("f4_data", 32'(out_data), 7);
        chk("f4_sat", 32'(out_sat), 0);
        chk_cnt("f4_count", 1);
        tick();

        // Single zero beat
        send(4'd0, 1'b1);
        chk("f5_valid", 32'(out_valid), 1);
        chk("f5_data", 32'(out_data), 0);
        chk("f5_sat", 32'(out_sat), 0);
        chk_cnt("f5_count", 1);
        tick();

        // Reset after two beats of 10 drops the partial frame
        send(4'd10, 1'b0);
        send(4'd10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_ready", 32'(in_ready), 1);
        send(4'd3, 1'b1);
        chk("f6_data", 32'(out_data), 3);
        chk_cnt("f6_count", 1);
        tick();

        // Reset while holding a result drops it
        out_ready = 1'b0;
        send(4'd5, 1'b1);
        chk("f7_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hold_valid", 32'(out_valid), 0);
        chk("rst_hold_data", 32'(out_data), 0);
        chk("rst_hold_ready", 32'(in_ready), 1);
        out_ready = 1'b1;

        // Idle gaps between beats 5, 0, 6 -> 11
        send(4'd5, 1'b0);
        tick();
        tick();
        send(4'd0, 1'b0);
        chk("f8_gap_valid", 32'(out_valid), 0);
        tick();
        send(4'd6, 1'b1);
        chk("f8_valid", 32'(out_valid), 1);
        chk("f8_data", 32'(out_data), 11);
        chk("f8_sat", 32'(out_sat), 0);
        chk_cnt("f8_count", 3);
        tick();
        chk("f8_done_valid", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
